// File: rtl/pa_out_stream_if.sv
// pa_out_stream_if: push, divider-control and status bundle for pa_out_stream.
// Macro PA_OUT_REPEAT_EN adds the repeat_en (circular pattern) signal.
interface pa_out_stream_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
);
    logic                         wr_en;
    logic [WIDTH-1:0]             wr_data;
    logic                         wr_ready;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         enable;
    logic [DIV_W-1:0]             div;
    logic                         clr_status;
    logic                         underflow;
    logic                         overflow;
    logic [WIDTH-1:0]             led_out;
`ifdef PA_OUT_REPEAT_EN
    logic                         repeat_en;
    modport master (
        output wr_en, wr_data, enable, div, clr_status, repeat_en,
        input  wr_ready, level, underflow, overflow, led_out
    );
    modport slave (
        input  wr_en, wr_data, enable, div, clr_status, repeat_en,
        output wr_ready, level, underflow, overflow, led_out
    );
`else
    modport master (
        output wr_en, wr_data, enable, div, clr_status,
        input  wr_ready, level, underflow, overflow, led_out
    );
    modport slave (
        input  wr_en, wr_data, enable, div, clr_status,
        output wr_ready, level, underflow, overflow, led_out
    );
`endif
endinterface

// File: rtl/pa_out_stream.sv
// pa_out_stream: FIFO-fed parallel output popped one word per divider tick.
// Macro PA_OUT_REPEAT_EN enables circular-pattern repeat mode.
module pa_out_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input logic             clock,
    input logic             reset,
    pa_out_stream_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] led_q, led_d, wr_word;
    logic             uf_q, uf_d, of_q, of_d, rpt_q, rpt_d;
    logic             ready, push, tick, pop, recirc;

    always_comb begin
        ready    = (level_q != LW'(DEPTH)) && !rpt_q;
        push     = bus.wr_en && ready;
        tick     = bus.enable && (cnt_q == '0);
        pop      = tick && (level_q != '0);
        recirc   = pop && rpt_q;
        cnt_d    = !bus.enable ? cnt_q : tick ? bus.div : cnt_q - DIV_W'(1);
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = (push || recirc) ? wr_ptr_q + PW'(1) : wr_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop && !rpt_q);
        led_d    = pop ? mem_q[rd_ptr_q] : led_q;
        wr_word  = recirc ? mem_q[rd_ptr_q] : bus.wr_data;
        // a new event in the same cycle as clr_status keeps the flag set
        uf_d     = (tick && level_q == '0) || (uf_q && !bus.clr_status);
        of_d     = (bus.wr_en && !ready) || (of_q && !bus.clr_status);
`ifdef PA_OUT_REPEAT_EN
        rpt_d    = bus.repeat_en;
`else
        rpt_d    = 1'b0;
`endif
    end

    // push and recirculation never coincide: repeat mode holds wr_ready low
    always_ff @(posedge clock) begin
        if (push || recirc) mem_q[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            led_q    <= '0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
            rpt_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            uf_q     <= uf_d;
            of_q     <= of_d;
            rpt_q    <= rpt_d;
        end
    end

    assign bus.wr_ready  = ready;
    assign bus.level     = level_q;
    assign bus.underflow = uf_q;
    assign bus.overflow  = of_q;
    assign bus.led_out   = led_q;
endmodule
